// File: rtl/stopwatch_pkg.sv
// Shared encodings and defaults for the stopwatch controller
// and the Counter block it drives.
package stopwatch_pkg;

  localparam int unsigned CLK_FREQ_DEF = 100_000_000;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'b00,
    ST_RUN   = 2'b01,
    ST_PAUSE = 2'b10,
    ST_ILL   = 2'b11
  } sw_state_e;

  function automatic sw_state_e ss_next(
    input sw_state_e st
  );
    sw_state_e nx;
    nx = ST_IDLE;
    unique case (st)
      ST_IDLE:  nx = ST_RUN;
      ST_RUN:   nx = ST_PAUSE;
      ST_PAUSE: nx = ST_RUN;
      default:  nx = ST_IDLE;
    endcase
    return nx;
  endfunction

endpackage

// File: rtl/debounce.sv
// Button conditioner: 2-flop synchronizer, stable-level
// debouncer and rising-edge press pulse.
module debounce #(
  parameter int unsigned DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn_i,
  output logic pulse_o
);

  localparam int unsigned CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [1:0]    sync_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;
  logic          lvl_q;
  logic          lvl_d;
  logic          prev_q;

  // Count edges where the synced input disagrees;
  // any agreeing edge restarts the window.
  always_comb begin
    cnt_d = '0;
    lvl_d = lvl_q;
    if (sync_q[1] != lvl_q) begin
      if (cnt_q >= LAST) begin
        lvl_d = ~lvl_q;
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= '0;
      cnt_q  <= '0;
      lvl_q  <= 1'b0;
      prev_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], btn_i};
      cnt_q  <= cnt_d;
      lvl_q  <= lvl_d;
      prev_q <= lvl_q;
    end
  end

  assign pulse_o = lvl_q & ~prev_q;

endmodule

// File: rtl/stopwatch_ctl.sv
// Stopwatch control FSM: two conditioned buttons drive
// registered run/clear commands into the Counter.
module stopwatch_ctl
  import stopwatch_pkg::*;
#(
  parameter int unsigned CLK_FREQ        = CLK_FREQ_DEF,
  parameter int unsigned DEBOUNCE_CYCLES = CLK_FREQ / 100
) (
  input  logic       clk,
  input  logic       init_regs_n,
  input  logic       btn_start_stop,
  input  logic       btn_reset,
  output logic       init_regs,
  output logic       count_enabled,
  output logic [1:0] state_out
);

  logic      ss_p;
  logic      rst_p;
  sw_state_e state_q;
  sw_state_e state_d;
  logic      clr_q;
  logic      clr_d;
  logic      run_q;

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_ss (
    .clk    (clk),
    .rst_n  (init_regs_n),
    .btn_i  (btn_start_stop),
    .pulse_o(ss_p)
  );

  debounce #(
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_db_rst (
    .clk    (clk),
    .rst_n  (init_regs_n),
    .btn_i  (btn_reset),
    .pulse_o(rst_p)
  );

  // Clear beats start/stop when both arrive together.
  always_comb begin
    state_d = state_q;
    clr_d   = 1'b0;
    priority case (1'b1)
      rst_p: begin
        state_d = ST_IDLE;
        clr_d   = 1'b1;
      end
      (state_q == ST_ILL): state_d = ST_IDLE;
      ss_p:                state_d = ss_next(state_q);
      default:             state_d = state_q;
    endcase
  end

  always_ff @(posedge clk or negedge init_regs_n) begin
    if (!init_regs_n) begin
      state_q <= ST_IDLE;
      clr_q   <= 1'b1;
      run_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      clr_q   <= clr_d;
      run_q   <= (state_d == ST_RUN);
    end
  end

  assign init_regs     = clr_q;
  assign count_enabled = run_q;
  assign state_out     = state_q;

endmodule

// File: tb/tb_stopwatch_ctl.sv
// Directed bench for stopwatch_ctl with a 4-cycle
// debounce window and 10 ns clock.
module tb_stopwatch_ctl;

  logic       clk;
  logic       init_regs_n;
  logic       btn_start_stop;
  logic       btn_reset;
  logic       init_regs;
  logic       count_enabled;
  logic [1:0] state_out;

  int n_vec;
  int n_err;
  int init_cnt;
  int rise_cnt;
  logic [1:0] st_prev;

  stopwatch_ctl #(
    .CLK_FREQ       (100_000_000),
    .DEBOUNCE_CYCLES(4)
  ) dut (
    .clk           (clk),
    .init_regs_n   (init_regs_n),
    .btn_start_stop(btn_start_stop),
    .btn_reset     (btn_reset),
    .init_regs     (init_regs),
    .count_enabled (count_enabled),
    .state_out     (state_out)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (init_regs) init_cnt++;
    if (st_prev == 2'b00 && state_out == 2'b01) rise_cnt++;
    st_prev = state_out;
  end

  task automatic chk(input string tag,
                     input logic [31:0] got,
                     input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic chk_out(input string tag,
                         input logic [1:0] st,
                         input logic ce,
                         input logic ir);
    chk({tag, ".state"}, 32'(state_out), 32'(st));
    chk({tag, ".ce"}, 32'(count_enabled), 32'(ce));
    chk({tag, ".init"}, 32'(init_regs), 32'(ir));
  endtask

  task automatic press_ss(input int hold);
    btn_start_stop = 1'b1;
    tick(hold);
    btn_start_stop = 1'b0;
    tick(10);
  endtask

  initial begin
    n_vec = 0;
    n_err = 0;
    init_cnt = 0;
    rise_cnt = 0;
    st_prev = 2'b00;
    init_regs_n = 1'b0;
    btn_start_stop = 1'b0;
    btn_reset = 1'b0;

    // reset held for 3 cycles
    tick(3);
    chk_out("rst", 2'b00, 1'b0, 1'b1);
    init_regs_n = 1'b1;
    tick(1);
    chk_out("rst_rel", 2'b00, 1'b0, 1'b0);
    tick(8);
    chk_out("rst_idle", 2'b00, 1'b0, 1'b0);

    // clean start: update lands on edge 7
    btn_start_stop = 1'b1;
    tick(6);
    chk_out("start_e6", 2'b00, 1'b0, 1'b0);
    tick(1);
    chk_out("start_e7", 2'b01, 1'b1, 1'b0);
    tick(5);
    btn_start_stop = 1'b0;
    tick(20);
    chk_out("start_rel", 2'b01, 1'b1, 1'b0);

    // pause / resume
    init_cnt = 0;
    btn_start_stop = 1'b1;
    tick(6);
    chk_out("pause_e6", 2'b01, 1'b1, 1'b0);
    tick(1);
    chk_out("pause_e7", 2'b10, 1'b0, 1'b0);
    tick(5);
    btn_start_stop = 1'b0;
    tick(10);
    chk_out("paused", 2'b10, 1'b0, 1'b0);
    press_ss(12);
    chk_out("resumed", 2'b01, 1'b1, 1'b0);
    chk("pause_init_cnt", 32'(init_cnt), 32'd0);

    // clear while running
    init_cnt = 0;
    btn_reset = 1'b1;
    tick(6);
    chk_out("clr_e6", 2'b01, 1'b1, 1'b0);
    tick(1);
    chk_out("clr_e7", 2'b00, 1'b0, 1'b1);
    tick(1);
    chk_out("clr_e8", 2'b00, 1'b0, 1'b0);
    tick(4);
    btn_reset = 1'b0;
    tick(10);
    chk("clr_init_cnt", 32'(init_cnt), 32'd1);
    chk_out("clr_idle", 2'b00, 1'b0, 1'b0);

    // bouncy press: 2-cycle toggles never fill the window
    rise_cnt = 0;
    for (int i = 0; i < 10; i++) begin
      btn_start_stop = (i % 2 == 0);
      tick(2);
      chk("bounce_idle", 32'(state_out), 32'd0);
    end
    btn_start_stop = 1'b1;
    tick(12);
    btn_start_stop = 1'b0;
    tick(10);
    chk("bounce_rise", 32'(rise_cnt), 32'd1);
    chk_out("bounce_run", 2'b01, 1'b1, 1'b0);

    // both buttons from PAUSED: clear wins
    press_ss(12);
    chk_out("conf_paused", 2'b10, 1'b0, 1'b0);
    init_cnt = 0;
    btn_start_stop = 1'b1;
    btn_reset = 1'b1;
    tick(7);
    chk_out("conf_e7", 2'b00, 1'b0, 1'b1);
    tick(5);
    btn_start_stop = 1'b0;
    btn_reset = 1'b0;
    tick(10);
    chk("conf_init_cnt", 32'(init_cnt), 32'd1);
    chk_out("conf_idle", 2'b00, 1'b0, 1'b0);

    // reset mid-debounce with button still held
    btn_start_stop = 1'b1;
    tick(4);
    init_regs_n = 1'b0;
    tick(2);
    chk_out("mid_rst", 2'b00, 1'b0, 1'b1);
    init_regs_n = 1'b1;
    tick(1);
    init_cnt = 0;
    rise_cnt = 0;
    chk_out("mid_e1", 2'b00, 1'b0, 1'b0);
    tick(5);
    chk_out("mid_e6", 2'b00, 1'b0, 1'b0);
    tick(1);
    chk_out("mid_e7", 2'b01, 1'b1, 1'b0);
    tick(10);
    btn_start_stop = 1'b0;
    tick(10);
    chk_out("mid_hold", 2'b01, 1'b1, 1'b0);
    chk("mid_init_cnt", 32'(init_cnt), 32'd0);
    chk("mid_rise", 32'(rise_cnt), 32'd1);

    $display("== %0d vectors applied, %0d miscompares ==",
             n_vec, n_err);
    $finish;
  end

endmodule
